fibo_seq_gen: RTL and testbench

Parametrised generalised-Fibonacci engine. Accepts a request (index n, seeds s0/s1) on a valid/ready input handshake. It iterates F(k)=F(k-1)+F(k-2) with F(0)=s0 and F(1)=s1. It returns F(n) plus a sticky overflow flag on a valid/ready output handshake. It replaces the free-running generator wherever a specific term, custom seeds (e.g. Lucas) or backpressure are needed.

---
 rtl/fibo_pkg.sv | 13 +
 rtl/fibo_step.sv | 13 +
 rtl/fibo_seq_gen.sv | 91 +++++++++
 tb/tb_fibo_seq_gen.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fibo_pkg.sv
// Shared types and default sizing for the generalised-Fibonacci engine.
package fibo_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } fibo_state_t;

   localparam int FIBO_WIDTH = 32;
   localparam int FIBO_IDX_W = 6;

endpackage

// File: rtl/fibo_step.sv
// One Fibonacci step: WIDTH-bit add of curr+prev with carry-out; purely combinational.
module fibo_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] curr_i,
   input  logic [WIDTH-1:0] prev_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             carry_o
);

   assign {carry_o, sum_o} = {1'b0, curr_i} + {1'b0, prev_i};

endmodule

// File: rtl/fibo_seq_gen.sv
// Computes F(n) for seeds s0/s1; result valid max(n,1) edges after accept.
// Holds the result in DONE until out_ready; accepts nothing while busy.
module fibo_seq_gen
   import fibo_pkg::*;
#(
   parameter int WIDTH = FIBO_WIDTH,
   parameter int IDX_W = FIBO_IDX_W
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IDX_W-1:0] in_n,
   input  logic [WIDTH-1:0] in_seed0,
   input  logic [WIDTH-1:0] in_seed1,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_value,
   output logic             out_ovf,
   output logic             busy
);

   fibo_state_t      state_q;
   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] curr_q;
   logic [IDX_W-1:0] cnt_q;
   logic             ovf_q;
   logic [WIDTH-1:0] out_value_q;
   logic             out_ovf_q;

   logic [WIDTH-1:0] sum_d;
   logic             carry_d;

   fibo_step #(.WIDTH(WIDTH)) u_step (
      .curr_i  (curr_q),
      .prev_i  (prev_q),
      .sum_o   (sum_d),
      .carry_o (carry_d)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         prev_q      <= '0;
         curr_q      <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         out_value_q <= '0;
         out_ovf_q   <= 1'b0;
      end else if (clear) begin
         // Abort drops any pending result; the last output values stay visible.
         state_q <= IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid) begin
                  prev_q  <= in_seed0;
                  curr_q  <= in_seed1;
                  cnt_q   <= in_n;
                  ovf_q   <= 1'b0;
                  state_q <= CALC;
               end
            end
            CALC: begin
               if (cnt_q >= IDX_W'(2)) begin
                  curr_q <= sum_d;
                  prev_q <= curr_q;
                  cnt_q  <= cnt_q - IDX_W'(1);
                  ovf_q  <= ovf_q | carry_d;
               end else begin
                  out_value_q <= (cnt_q == '0) ? prev_q : curr_q;
                  out_ovf_q   <= ovf_q;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign out_value = out_value_q;
   assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_fibo_seq_gen.sv
// Directed and randomised requests against an arithmetic reference of the Fibonacci recurrence.
module tb_fibo_seq_gen;

   localparam int WIDTH = 32;
   localparam int IDX_W = 6;

   logic             clock = 1'b0;
   logic             reset_n;
   logic             clear;
   logic             in_valid;
   logic             in_ready;
   logic [IDX_W-1:0] in_n;
   logic [WIDTH-1:0] in_seed0;
   logic [WIDTH-1:0] in_seed1;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_value;
   logic             out_ovf;
   logic             busy;

   int n_cmp = 0;
   int n_err = 0;

   fibo_seq_gen #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_n      (in_n),
      .in_seed0  (in_seed0),
      .in_seed1  (in_seed1),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_value (out_value),
      .out_ovf   (out_ovf),
      .busy      (busy)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: iterate the recurrence in 64-bit arithmetic, flag any sum reaching 2^WIDTH.
   task automatic fib_ref(input int n, input longint unsigned s0, input longint unsigned s1,
                          output longint unsigned val, output logic ovf);
      longint unsigned a, b, t;
      longint unsigned modv;
      modv = 64'd1 << WIDTH;
      a = s0;
      b = s1;
      ovf = 1'b0;
      for (int k = 2; k <= n; k++) begin
         t = a + b;
         if (t >= modv) ovf = 1'b1;
         t = t % modv;
         a = b;
         b = t;
      end
      val = (n == 0) ? a : b;
   endtask

   task automatic do_req(input int n, input logic [WIDTH-1:0] s0, input logic [WIDTH-1:0] s1,
                         input int hold);
      longint unsigned exp_val;
      logic            exp_ovf;
      int              lat;
      fib_ref(n, s0, s1, exp_val, exp_ovf);
      in_n     = IDX_W'(n);
      in_seed0 = s0;
      in_seed1 = s1;
      in_valid = 1'b1;
      check("acc_in_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      in_n     = IDX_W'($urandom);
      in_seed0 = $urandom;
      in_seed1 = $urandom;
      check("calc_in_ready", in_ready, 0);
      check("calc_busy", busy, 1);
      lat = 0;
      while (!out_valid && lat < 100) begin
         tick();
         lat++;
      end
      check("latency", lat, (n > 1) ? n : 1);
      check("value", out_value, exp_val);
      check("ovf", out_ovf, exp_ovf);
      for (int i = 0; i < hold; i++) begin
         tick();
         check("hold_valid", out_valid, 1);
         check("hold_value", out_value, exp_val);
         check("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("taken_valid", out_valid, 0);
      check("taken_in_ready", in_ready, 1);
   endtask

   initial begin
      logic [WIDTH-1:0] kept;
      int               lat;
      reset_n   = 1'b0;
      clear     = 1'b0;
      in_valid  = 1'b0;
      in_n      = '0;
      in_seed0  = '0;
      in_seed1  = '0;
      out_ready = 1'b0;
      tick();
      tick();
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_value", out_value, 0);
      check("rst_ovf", out_ovf, 0);
      reset_n = 1'b1;
      tick();

      do_req(10, 0, 1, 0);
      check("f10", out_value, 55);
      do_req(0, 0, 1, 0);
      do_req(1, 0, 1, 0);
      do_req(47, 0, 1, 0);
      check("f47", out_value, 64'd2971215073);
      check("f47_ovf", out_ovf, 0);
      do_req(48, 0, 1, 0);
      check("f48", out_value, 64'd512559680);
      check("f48_ovf", out_ovf, 1);
      do_req(5, 0, 1, 0);
      check("f5_ovf_cleared", out_ovf, 0);
      do_req(5, 2, 1, 0);
      check("lucas5", out_value, 11);

      // Backpressure followed by an immediate back-to-back request.
      do_req(7, 3, 4, 5);
      do_req(2, 9, 9, 0);

      // Reset in the middle of a long calculation.
      in_n = 6'd20; in_seed0 = 0; in_seed1 = 1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      reset_n = 1'b0;
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_value", out_value, 0);
      tick();
      reset_n = 1'b1;
      tick();
      check("post_rst_in_ready", in_ready, 1);

      // Clear in DONE beats out_ready and a simultaneous request.
      in_n = 6'd3; in_seed0 = 5; in_seed1 = 6; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin
         tick();
         lat++;
      end
      check("clr_pre_valid", out_valid, 1);
      kept = out_value;
      check("clr_pre_value", kept, 17);
      clear = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
      tick();
      clear = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
      check("clr_out_valid", out_valid, 0);
      check("clr_busy", busy, 0);
      check("clr_value_kept", out_value, 17);
      tick();
      check("clr_no_accept", busy, 0);
      do_req(4, 1, 1, 1);

      // Randomised requests with random backpressure.
      for (int r = 0; r < 25; r++) begin
         do_req(int'($urandom_range(0, (1 << IDX_W) - 1)), $urandom, $urandom,
                int'($urandom_range(0, 3)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
